// File: rtl/updown_counter_hex_if.sv
// updown_counter_hex_if
//   Bundles the control inputs and the count/display outputs of
//   updown_counter_hex. The master side is whatever drives the counter
//   (switch/key logic or a testbench). The slave side is the counter itself.
//
//   Signals (WIDTH bits of count, DIGITS = WIDTH/4 display digits):
//     enable      master->slave  count step enable
//     up          master->slave  direction, 1 = increment, 0 = decrement
//     load        master->slave  synchronous load strobe
//     load_value  master->slave  WIDTH-bit value to load (clamped to MAX)
//     count       slave->master  registered count
//     tc          slave->master  registered one-cycle terminal-count pulse
//     hex         slave->master  7*DIGITS active-low segment outputs
interface updown_counter_hex_if #(
    parameter int WIDTH = 8
) ();
    logic                       enable;
    logic                       up;
    logic                       load;
    logic [WIDTH-1:0]           load_value;
    logic [WIDTH-1:0]           count;
    logic                       tc;
    logic [7*(WIDTH/4)-1:0]     hex;

    modport master (
        output enable, up, load, load_value,
        input  count, tc, hex
    );

    modport slave (
        input  enable, up, load, load_value,
        output count, tc, hex
    );
endinterface

// File: rtl/updown_counter_hex.sv
// updown_counter_hex
//   Synchronously loadable up/down counter with a programmable top value
//   (MAX), wrap or saturate behaviour at both bounds, a registered
//   terminal-count pulse and an active-low seven-segment decode of every
//   hex digit of the count.
//
//   Parameters:
//     WIDTH     counter width, multiple of 4, at least 4
//     MAX       highest count value, 1 <= MAX <= 2**WIDTH-1
//     SATURATE  0 = wrap at the bounds, 1 = hold at the bounds
//
//   Ports:
//     clock  rising-edge clock
//     clear  asynchronous active-low reset (count = 0, tc = 0)
//     bus    slave side of updown_counter_hex_if (enable, up, load,
//            load_value in; count, tc, hex out)
module updown_counter_hex #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic                clock,
    input  logic                clear,
    updown_counter_hex_if.slave bus
);

    localparam int DIGITS = WIDTH / 4;

    logic [WIDTH-1:0]    count_p0;
    logic                tc_p0;
    logic [WIDTH-1:0]    count_nxt;
    logic                tc_nxt;
    logic [7*DIGITS-1:0] hex_w;

    // Loaded values above MAX are clamped so the count never leaves 0..MAX.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX) ? MAX : v;
    endfunction

    // Returns {tc, next count} for an increment. The bound test uses >= so
    // the counter still recovers if count were ever above MAX.
    function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] bound_v;
        if (c >= MAX) begin
            bound_v = SATURATE ? MAX : {WIDTH{1'b0}};
            return {1'b1, bound_v};
        end
        return {1'b0, c + 1'b1};
    endfunction

    // Returns {tc, next count} for a decrement; wraps to MAX, not 2**WIDTH-1.
    function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] bound_v;
        if (c == {WIDTH{1'b0}}) begin
            bound_v = SATURATE ? {WIDTH{1'b0}} : MAX;
            return {1'b1, bound_v};
        end
        return {1'b0, c - 1'b1};
    endfunction

    // Active-low segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Priority: load, then enable, then hold. tc is a pulse, so it defaults low.
    always_comb begin
        count_nxt = count_p0;
        tc_nxt    = 1'b0;
        if (bus.load) begin
            count_nxt = clamp_load(bus.load_value);
        end else if (bus.enable) begin
            if (bus.up) begin
                {tc_nxt, count_nxt} = step_up(count_p0);
            end else begin
                {tc_nxt, count_nxt} = step_down(count_p0);
            end
        end
    end

    // ---- stage p0: count and terminal-count registers ----
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_p0 <= '0;
            tc_p0    <= 1'b0;
        end else begin
            count_p0 <= count_nxt;
            tc_p0    <= tc_nxt;
        end
    end

    // ---- combinational display decode from the registered count ----
    always_comb begin
        hex_w = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hex_w[7*i +: 7] = seg7(count_p0[4*i +: 4]);
        end
    end

    assign bus.count = count_p0;
    assign bus.tc    = tc_p0;
    assign bus.hex   = hex_w;

endmodule

// File: tb/tb_updown_counter_hex.sv
module tb_updown_counter_hex;

    logic clock;
    logic clear;

    int checks = 0;
    int errors = 0;

    // Four configurations: A = 8-bit default, B = MAX 59 wrap,
    // C = MAX 59 saturate, D = 16-bit default.
    updown_counter_hex_if #(.WIDTH(8))  ifa ();
    updown_counter_hex_if #(.WIDTH(8))  ifb ();
    updown_counter_hex_if #(.WIDTH(8))  ifc ();
    updown_counter_hex_if #(.WIDTH(16)) ifd ();

    updown_counter_hex #(.WIDTH(8)) ua (.clock(clock), .clear(clear), .bus(ifa));
    updown_counter_hex #(.WIDTH(8), .MAX(8'd59), .SATURATE(1'b0)) ub (.clock(clock), .clear(clear), .bus(ifb));
    updown_counter_hex #(.WIDTH(8), .MAX(8'd59), .SATURATE(1'b1)) uc (.clock(clock), .clear(clear), .bus(ifc));
    updown_counter_hex #(.WIDTH(16)) ud (.clock(clock), .clear(clear), .bus(ifd));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    byte unsigned seg_tab[16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                                  8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};

    function automatic longint mhex(input longint c, input int digits);
        longint h = 0;
        for (int i = 0; i < digits; i++)
            h = h | (longint'(seg_tab[(c >> (4*i)) & 15]) << (7*i));
        return h;
    endfunction

    // Modular arithmetic over 0..mx for wrap, min/max clipping for saturate.
    task automatic mstep(input longint mx, input bit sat, input bit ld, input longint lv,
                         input bit en, input bit up, input longint c,
                         output longint c_out, output bit t_out);
        c_out = c;
        t_out = 1'b0;
        if (ld) begin
            c_out = (lv > mx) ? mx : lv;
        end else if (en) begin
            if (up) begin
                t_out = (c == mx);
                c_out = sat ? ((c + 1 > mx) ? mx : c + 1) : (c + 1) % (mx + 1);
            end else begin
                t_out = (c == 0);
                c_out = sat ? ((c - 1 < 0) ? 0 : c - 1) : (c + mx) % (mx + 1);
            end
        end
    endtask

    typedef struct {
        bit             ld;
        logic [7:0]     lv;
        bit             en;
        bit             up;
        logic [7:0]     exp_count;
        bit             exp_tc;
    } vec_t;

    vec_t vecs[12];

    longint mx[4]  = '{255, 59, 59, 65535};
    bit     sat[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int     dg[4]  = '{2, 2, 2, 4};
    longint mc[4];
    bit     mt[4];

    initial begin
        bit     ld[4], en[4], up[4];
        longint lv[4];
        longint act_c[4], act_h[4];
        bit     act_t[4];
        longint nc;
        bit     nt;

        vecs[0]  = '{1'b1, 8'd58,  1'b0, 1'b0, 8'd58, 1'b0};
        vecs[1]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd59, 1'b0};
        vecs[2]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd0,  1'b1};
        vecs[3]  = '{1'b0, 8'd0,   1'b1, 1'b1, 8'd1,  1'b0};
        vecs[4]  = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd0,  1'b0};
        vecs[5]  = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd59, 1'b1};
        vecs[6]  = '{1'b0, 8'd0,   1'b0, 1'b0, 8'd59, 1'b0};
        vecs[7]  = '{1'b1, 8'd200, 1'b0, 1'b0, 8'd59, 1'b0};
        vecs[8]  = '{1'b1, 8'hA5,  1'b1, 1'b1, 8'd59, 1'b0};
        vecs[9]  = '{1'b1, 8'd3,   1'b0, 1'b0, 8'd3,  1'b0};
        vecs[10] = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd2,  1'b0};
        vecs[11] = '{1'b0, 8'd0,   1'b0, 1'b1, 8'd2,  1'b0};

        {ifa.enable, ifa.up, ifa.load, ifa.load_value} = '0;
        {ifb.enable, ifb.up, ifb.load, ifb.load_value} = '0;
        {ifc.enable, ifc.up, ifc.load, ifc.load_value} = '0;
        {ifd.enable, ifd.up, ifd.load, ifd.load_value} = '0;

        // Reset state
        clear = 1'b0;
        #2;
        check("reset_count", ifa.count, 8'h00);
        check("reset_tc", ifa.tc, 1'b0);
        check("reset_hex", ifa.hex, {7'h40, 7'h40});
        check("reset_hex16", ifd.hex, {4{7'h40}});
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b1;

        // 18 up steps
        ifa.enable = 1'b1;
        ifa.up     = 1'b1;
        repeat (18) begin
            tick();
            check("up_tc", ifa.tc, 1'b0);
        end
        ifa.enable = 1'b0;
        check("up18_count", ifa.count, 8'h12);
        check("up18_hex", ifa.hex, {7'h79, 7'h24});

        // Table: wrap and clamp on B (MAX 59, wrap)
        for (int i = 0; i < 12; i++) begin
            ifb.load       = vecs[i].ld;
            ifb.load_value = vecs[i].lv;
            ifb.enable     = vecs[i].en;
            ifb.up         = vecs[i].up;
            tick();
            check($sformatf("vec%0d_count", i), ifb.count, vecs[i].exp_count);
            check($sformatf("vec%0d_tc", i), ifb.tc, vecs[i].exp_tc);
        end
        {ifb.enable, ifb.up, ifb.load, ifb.load_value} = '0;

        // Saturate on C: three down steps at 0, then three up attempts at MAX
        ifc.enable = 1'b1;
        ifc.up     = 1'b0;
        repeat (3) begin
            tick();
            check("sat_down_count", ifc.count, 8'd0);
            check("sat_down_tc", ifc.tc, 1'b1);
        end
        ifc.enable = 1'b0;
        tick();
        check("sat_idle_tc", ifc.tc, 1'b0);
        ifc.load = 1'b1;
        ifc.load_value = 8'd58;
        tick();
        ifc.load = 1'b0;
        ifc.enable = 1'b1;
        ifc.up = 1'b1;
        tick();
        check("sat_up_59", ifc.count, 8'd59);
        check("sat_up_59_tc", ifc.tc, 1'b0);
        repeat (2) begin
            tick();
            check("sat_hold_count", ifc.count, 8'd59);
            check("sat_hold_tc", ifc.tc, 1'b1);
        end
        ifc.enable = 1'b0;

        // Load priority over enable on A
        ifa.load = 1'b1;
        ifa.enable = 1'b1;
        ifa.up = 1'b1;
        ifa.load_value = 8'hA5;
        tick();
        check("ldpri_count", ifa.count, 8'hA5);
        check("ldpri_tc", ifa.tc, 1'b0);
        check("ldpri_hex", ifa.hex, {7'h08, 7'h12});

        // Count to 7, then asynchronous clear between edges
        ifa.load_value = 8'h00;
        tick();
        ifa.load = 1'b0;
        repeat (7) tick();
        check("pre_clear_count", ifa.count, 8'd7);
        #2;
        clear = 1'b0;
        #1;
        check("async_clear_count", ifa.count, 8'd0);
        check("async_clear_tc", ifa.tc, 1'b0);
        check("async_clear_hex", ifa.hex, {7'h40, 7'h40});
        clear = 1'b1;

        // Direction flip every edge
        for (int k = 0; k < 6; k++) begin
            ifa.up = (k % 2 == 0);
            tick();
            check($sformatf("flip%0d_count", k), ifa.count, (k % 2 == 0) ? 8'd1 : 8'd0);
            check($sformatf("flip%0d_tc", k), ifa.tc, 1'b0);
        end
        ifa.up = 1'b0;
        tick();
        check("flip_wrap_count", ifa.count, 8'hFF);
        check("flip_wrap_tc", ifa.tc, 1'b1);
        ifa.enable = 1'b0;
        tick();
        check("flip_idle_tc", ifa.tc, 1'b0);

        // 16-bit wrap on D
        ifd.load = 1'b1;
        ifd.load_value = 16'hFFFF;
        tick();
        check("w16_load", ifd.count, 16'hFFFF);
        ifd.load = 1'b0;
        ifd.enable = 1'b1;
        ifd.up = 1'b1;
        tick();
        check("w16_wrap_count", ifd.count, 16'h0000);
        check("w16_wrap_tc", ifd.tc, 1'b1);
        check("w16_wrap_hex", ifd.hex, {4{7'h40}});
        ifd.enable = 1'b0;

        // Randomised run against the model on all four configurations
        #2;
        clear = 1'b0;
        #2;
        clear = 1'b1;
        for (int j = 0; j < 4; j++) begin
            mc[j] = 0;
            mt[j] = 1'b0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 4; j++) begin
                ld[j] = ($urandom_range(0, 11) == 0);
                en[j] = ($urandom_range(0, 3) != 0);
                up[j] = $urandom_range(0, 1);
                if ($urandom_range(0, 3) == 0)
                    lv[j] = mx[j] - $urandom_range(0, 2);
                else if (j == 3)
                    lv[j] = $urandom_range(0, 65535);
                else
                    lv[j] = $urandom_range(0, 255);
            end
            ifa.load = ld[0]; ifa.enable = en[0]; ifa.up = up[0]; ifa.load_value = 8'(lv[0]);
            ifb.load = ld[1]; ifb.enable = en[1]; ifb.up = up[1]; ifb.load_value = 8'(lv[1]);
            ifc.load = ld[2]; ifc.enable = en[2]; ifc.up = up[2]; ifc.load_value = 8'(lv[2]);
            ifd.load = ld[3]; ifd.enable = en[3]; ifd.up = up[3]; ifd.load_value = 16'(lv[3]);
            tick();
            for (int j = 0; j < 4; j++) begin
                mstep(mx[j], sat[j], ld[j], lv[j], en[j], up[j], mc[j], nc, nt);
                mc[j] = nc;
                mt[j] = nt;
            end
            act_c[0] = ifa.count; act_t[0] = ifa.tc; act_h[0] = ifa.hex;
            act_c[1] = ifb.count; act_t[1] = ifb.tc; act_h[1] = ifb.hex;
            act_c[2] = ifc.count; act_t[2] = ifc.tc; act_h[2] = ifc.hex;
            act_c[3] = ifd.count; act_t[3] = ifd.tc; act_h[3] = ifd.hex;
            for (int j = 0; j < 4; j++) begin
                check($sformatf("rnd%0d_dut%0d_count", n, j), act_c[j], mc[j]);
                check($sformatf("rnd%0d_dut%0d_tc", n, j), act_t[j], mt[j]);
                check($sformatf("rnd%0d_dut%0d_hex", n, j), act_h[j], mhex(mc[j], dg[j]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_counter_hex.md
# updown_counter_hex

Parametrised, synchronously loadable up/down counter with a programmable modulus, a selectable wrap or saturate mode, a registered terminal-count pulse and built-in active-low seven-segment decode for every hex digit of the count. It is the next-generation counter for board-level designs. It replaces fixed 8-bit, up-only, enable-chained counters that feed separate per-nibble display decoders. It sits between debounced switch/key inputs and the HEX displays, and it can also be used headless as a general event counter.

## Interface
- WIDTH, 8: counter width in bits. Must be a multiple of 4 and at least 4. DIGITS = WIDTH/4 is derived.
- MAX, 2**WIDTH-1: highest count value (modulus is MAX+1). Must satisfy 1 ≤ MAX ≤ 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at bounds; 1 = hold at bounds.

- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-low reset
- enable  in  1  count step enable
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous load strobe
- load_value  in  WIDTH  value to load
- count  out  WIDTH  current count (registered)
- tc  out  1  terminal-count pulse (registered, one cycle)
- hex  out  7*DIGITS  segment outputs, active-low
  - digit i is hex[7i+6:7i] and shows count[4i+3:4i]
  - within each digit, bit 0 = segment a through bit 6 = segment g

## Operation
- **Reset:** clear low drives count = 0 and tc = 0 immediately, with no clock needed. hex then shows 0 on every digit (7'h40 each).
- **Priority per rising edge (clear high):** load, then enable, then hold.
- **Load:**
  - count ← load_value if load_value ≤ MAX; otherwise count ← MAX (clamped).
  - tc ← 0. Load overrides enable and up in the same cycle.
- **Enable with up = 1:**
  - count < MAX: count ← count+1, tc ← 0.
  - count = MAX: count ← 0 if SATURATE=0, or holds at MAX if SATURATE=1. tc ← 1 in both cases.
- **Enable with up = 0:**
  - count > 0: count ← count-1, tc ← 0.
  - count = 0: count ← MAX if SATURATE=0, or holds at 0 if SATURATE=1. tc ← 1 in both cases.
- **Idle (no load, no enable):** count holds, tc ← 0.
- **Saturated hold:** in SATURATE=1 mode, tc re-asserts on every enabled step attempted at the bound.
- **Arithmetic:** all arithmetic is WIDTH bits, unsigned, and compares against MAX, never 2**WIDTH. count never exceeds MAX.
- **Display decode:** purely combinational from count. Active-low hex patterns (g..a) for nibble 0–F:
  - 0–7: 40, 79, 24, 30, 19, 12, 02, 78
  - 8–F: 00, 10, 08, 03, 46, 21, 06, 0E
- **State:** the only state is the count register and the tc register. There is no other FSM.

## Timing
- count changes only on a rising clock edge, or asynchronously on clear falling.
- Latency:
  - enable or load sampled at edge N → new count visible after edge N.
  - tc is high for exactly the cycle after edge N in which the bound event occurred.
- hex follows count combinationally in the same cycle, with zero added latency.
- Direction change takes effect on the same edge it is sampled; no settle cycle is required.
- Reset asserted mid-count clears immediately. Release of clear is synchronised externally. The first edge with clear high obeys the normal rules.
- All inputs are sampled only at the rising edge; load_value needs to be stable only around that edge.

## Test plan
- **Reset and count up:** WIDTH=8, default MAX.
  - Reset → count=0x00, tc=0, hex=0x40_40.
  - 18 enabled up edges → count=0x12, hex = {0x79, 0x24}.
- **Wrap up:** MAX=59, SATURATE=0, load 58, 2 up steps.
  - Counts go 59 → 0. tc=1 only in the cycle after the 59→0 edge.
- **Wrap down and saturate:**
  - MAX=59, SATURATE=0, count=0, 1 down step → count=59, tc pulse.
  - SATURATE=1, count=0, 3 down steps → count stays 0, tc high for 3 cycles.
- **Load priority and clamp:**
  - load=1, enable=1, load_value=0xA5 → count=0xA5 (no step), hex = {0x08, 0x12}.
  - With MAX=59, load_value=200 → count=59.
- **Mid-operation reset and direction flip:**
  - Count up to 7, assert clear between edges → count=0 at once, tc=0.
  - After release, alternate up/down every edge for 6 edges → count toggles 1, 0, 1, 0, 1, 0, with no tc.
  - Then 1 down step → count=MAX, tc pulse.
- **Width scaling:** WIDTH=16.
  - Load 0xFFFF, 1 up step → count=0x0000, tc pulse, hex = 0x40 on all 4 digits.
